// File: rtl/pool_reader_if.sv
// pool_reader_if -- output beat channel of pool_reader.
//   out_vld  : beat valid (source -> sink)
//   out_rdy  : sink ready (sink -> source)
//   out_d1/2/3 : channel 0/1/2 element at the current position
//   out_cnt  : position index of the current beat
//   out_last : high with the final position's beat
// master = beat source (pool_reader), slave = beat sink.
interface pool_reader_if #(
  parameter int DW = 8
);
  logic          out_vld;
  logic          out_rdy;
  logic [DW-1:0] out_d1;
  logic [DW-1:0] out_d2;
  logic [DW-1:0] out_d3;
  logic [3:0]    out_cnt;
  logic          out_last;

  modport master (
    output out_vld,
    input  out_rdy,
    output out_d1,
    output out_d2,
    output out_d3,
    output out_cnt,
    output out_last
  );

  modport slave (
    input  out_vld,
    output out_rdy,
    input  out_d1,
    input  out_d2,
    input  out_d3,
    input  out_cnt,
    input  out_last
  );
endinterface

// File: rtl/pool_reader.sv
// pool_reader -- snapshots a flat CH x POS pool buffer on start and streams it
// out one position per beat (channels 0..2 side by side) under valid/ready.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin readout (accepted only when idle)
//   clr        : synchronous abort back to idle (wins over start)
//   pool_lin   : flat buffer, element (c,p) at bit offset (c*POS+p)*DW
//   out_if     : beat channel (out_vld/out_rdy/out_d1..3/out_cnt/out_last)
//   busy       : high whenever not idle
//   done       : one-cycle pulse after the final beat is accepted
// All outputs decode from registers only (state, cnt, shadow copy).
module pool_reader #(
  parameter int DW  = 8,
  parameter int CH  = 3,
  parameter int POS = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   clr,
  input  logic [CH*POS*DW-1:0]   pool_lin,
  pool_reader_if.master          out_if,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = 4;
  localparam logic [CW-1:0] LAST_CNT = CW'(POS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CH*POS*DW-1:0]  shadow_q;
  logic                  capture;
  logic [DW-1:0]         d1, d2, d3;

  // State and counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Shadow copy; only reloaded on an accepted start, kept across clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else if (capture) begin
      shadow_q <= pool_lin;
    end
  end

  // Next-state / counter logic. In SEND out_vld is 1, so out_rdy alone
  // qualifies a transfer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (clr) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            capture = 1'b1;
            cnt_d   = '0;
            state_d = S_SEND;
          end
        end
        S_SEND: begin
          if (out_if.out_rdy) begin
            if (cnt_q == LAST_CNT) begin
              cnt_d   = '0;
              state_d = S_DONE;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Per-channel element select at the current position
  always_comb begin
    d1 = '0;
    d2 = '0;
    d3 = '0;
    for (int unsigned p = 0; p < POS; p++) begin
      if (cnt_q == CW'(p)) begin
        d1 = shadow_q[(0 * POS + p) * DW +: DW];
        d2 = shadow_q[(1 * POS + p) * DW +: DW];
        d3 = shadow_q[(2 * POS + p) * DW +: DW];
      end
    end
  end

  assign out_if.out_vld  = (state_q == S_SEND);
  assign out_if.out_last = (state_q == S_SEND) && (cnt_q == LAST_CNT);
  assign out_if.out_cnt  = (state_q == S_SEND) ? cnt_q : '0;
  assign out_if.out_d1   = d1;
  assign out_if.out_d2   = d2;
  assign out_if.out_d3   = d3;

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_pool_reader.sv
// tb_pool_reader -- directed bench for pool_reader (DW=8, CH=3, POS=9).
module tb_pool_reader;

  localparam int DW  = 8;
  localparam int CH  = 3;
  localparam int POS = 9;

  logic                  clk;
  logic                  rst_n;
  logic                  start;
  logic                  clr;
  logic [CH*POS*DW-1:0]  pool_lin;
  logic                  busy;
  logic                  done;

  int tests;
  int fails;

  pool_reader_if #(.DW(DW)) bus ();

  pool_reader #(.DW(DW), .CH(CH), .POS(POS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .clr      (clr),
    .pool_lin (pool_lin),
    .out_if   (bus.master),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_ramp();
    for (int k = 0; k < CH * POS; k++) pool_lin[k*DW +: DW] = 8'(k);
  endtask

  // Checks the beat for position i (ramp data: i, 9+i, 18+i)
  task automatic chk_beat(input string tag, input int i);
    chk({tag, ".vld"},  32'(bus.out_vld),  32'd1);
    chk({tag, ".cnt"},  32'(bus.out_cnt),  32'(i));
    chk({tag, ".d1"},   32'(bus.out_d1),   32'(i));
    chk({tag, ".d2"},   32'(bus.out_d2),   32'(9 + i));
    chk({tag, ".d3"},   32'(bus.out_d3),   32'(18 + i));
    chk({tag, ".last"}, 32'(bus.out_last), (i == 8) ? 32'd1 : 32'd0);
    chk({tag, ".busy"}, 32'(busy),         32'd1);
    chk({tag, ".done"}, 32'(done),         32'd0);
  endtask

  // Called at the negedge right after the capture edge. Walks all 9 beats,
  // optionally stalling, optionally poking start mid-stream / in DONE.
  task automatic stream(input string tag, input int stall_at, input int stall_len,
                        input int poke_at, input bit poke_done);
    for (int i = 0; i < POS; i++) begin
      if (i == stall_at) begin
        bus.out_rdy = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          chk_beat({tag, ".stall"}, i);
          @(negedge clk);
        end
        bus.out_rdy = 1'b1;
      end
      if (i == poke_at) start = 1'b1;
      chk_beat(tag, i);
      @(negedge clk);
      start = 1'b0;
    end
    if (poke_done) start = 1'b1;
    chk({tag, ".done"},     32'(done),         32'd1);
    chk({tag, ".done_vld"}, 32'(bus.out_vld),  32'd0);
    chk({tag, ".done_cnt"}, 32'(bus.out_cnt),  32'd0);
    chk({tag, ".done_lst"}, 32'(bus.out_last), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".post_done"}, 32'(done),        32'd0);
    chk({tag, ".post_busy"}, 32'(busy),        32'd0);
    @(negedge clk);
    chk({tag, ".idle_busy"}, 32'(busy),        32'd0);
    chk({tag, ".idle_vld"},  32'(bus.out_vld), 32'd0);
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    clr         = 1'b0;
    pool_lin    = '0;
    bus.out_rdy = 1'b1;
    load_ramp();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.vld",  32'(bus.out_vld),  32'd0);
    chk("rst.last", 32'(bus.out_last), 32'd0);
    chk("rst.cnt",  32'(bus.out_cnt),  32'd0);
    chk("rst.busy", 32'(busy),         32'd0);
    chk("rst.done", 32'(done),         32'd0);
    rst_n = 1'b1;

    // Plain readout, ready always high
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stream("plain", -1, 0, -1, 1'b0);

    // Backpressure: 3 stall cycles at cnt4
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stream("stall", 4, 3, -1, 1'b0);

    // Buffer overwritten after capture must not leak into the stream
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pool_lin = '1;
    stream("shadow", -1, 0, -1, 1'b0);
    load_ramp();

    // start at cnt3 and during DONE both ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pool_lin = '1;
    stream("restart", -1, 0, 3, 1'b1);
    load_ramp();

    // clr at cnt5 aborts without done
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    chk_beat("clr.pre", 5);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr.vld",  32'(bus.out_vld), 32'd0);
    chk("clr.busy", 32'(busy),        32'd0);
    chk("clr.done", 32'(done),        32'd0);
    chk("clr.cnt",  32'(bus.out_cnt), 32'd0);
    @(negedge clk);
    chk("clr.done2", 32'(done),       32'd0);

    // clr and start together: clr wins, nothing starts
    clr   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    clr   = 1'b0;
    start = 1'b0;
    chk("clrstart.busy", 32'(busy),        32'd0);
    chk("clrstart.vld",  32'(bus.out_vld), 32'd0);

    // Fresh start after clr restarts from cnt0
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stream("after_clr", -1, 0, -1, 1'b0);

    // Asynchronous reset mid-readout at cnt2
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk_beat("arst.pre", 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.vld",  32'(bus.out_vld),  32'd0);
    chk("arst.last", 32'(bus.out_last), 32'd0);
    chk("arst.cnt",  32'(bus.out_cnt),  32'd0);
    chk("arst.d1",   32'(bus.out_d1),   32'd0);
    chk("arst.d2",   32'(bus.out_d2),   32'd0);
    chk("arst.d3",   32'(bus.out_d3),   32'd0);
    chk("arst.busy", 32'(busy),         32'd0);
    chk("arst.done", 32'(done),         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stream("after_rst", -1, 0, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pool_reader.md
POOL_READER -- requirements
Module: pool_reader

Interface
REQ-001 Parameter DW, default 8, width of one pooled element in bits.
REQ-002 Parameter CH, default 3, number of channels per position.
REQ-003 Parameter POS, default 9, positions per channel (3x3 window).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin readout; honoured only in IDLE.
REQ-007 clr  input  1  synchronous abort; returns the block to IDLE from any state.
REQ-008 pool_lin  input  CH*POS*DW  flat pool buffer; element (c,p) is at bit offset (c*POS+p)*DW.
REQ-009 out_vld  output  1  beat valid.
REQ-010 out_rdy  input  1  downstream ready.
REQ-011 out_d1, out_d2, out_d3  output  DW each  channel 0/1/2 element at the current position.
REQ-012 out_cnt  output  4  current position index, 0..POS-1.
REQ-013 out_last  output  1  high with the beat for position POS-1.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse after the final beat is accepted.

Function
REQ-016 The FSM SHALL have states IDLE, SEND and DONE; the encoding is free.
REQ-017 In IDLE, start=1 SHALL capture pool_lin into an internal shadow register, clear the position counter to 0 and move to SEND on the same edge.
REQ-018 Readout SHALL use only the shadow copy; pool_lin changes after the capture edge SHALL NOT affect output data.
REQ-019 start while busy=1 SHALL be ignored, with no recapture and no counter change.
REQ-020 In SEND, out_vld SHALL be 1; out_dN SHALL equal shadow[((N-1)*POS+cnt)*DW +: DW]; out_cnt SHALL equal cnt; out_last SHALL equal (cnt==POS-1).
REQ-021 First-beat latency: start sampled at edge t SHALL give out_vld=1 in the cycle after edge t.
REQ-022 A beat SHALL transfer when out_vld & out_rdy are both high at a rising edge.
REQ-023 On a transfer with cnt<POS-1, cnt SHALL increment by 1.
REQ-024 On a transfer with cnt==POS-1, the FSM SHALL go to DONE and cnt SHALL return to 0.
REQ-025 While out_vld=1 and out_rdy=0, out_d1..3, out_cnt and out_last SHALL hold stable.
REQ-026 With out_rdy held high, one beat SHALL transfer per cycle, so a full readout is POS cycles.
REQ-027 In DONE, done SHALL be 1 for exactly one cycle and the FSM SHALL then return to IDLE; start is ignored in DONE.
REQ-028 Outside SEND, out_vld and out_last SHALL be 0 and out_cnt SHALL be 0.
REQ-029 clr=1 SHALL force IDLE and cnt=0, deassert out_vld, and suppress done; the shadow register is retained.
REQ-030 If clr and start are high in the same cycle, clr SHALL win and no capture SHALL occur.
REQ-031 All outputs SHALL be driven directly from registers (FSM state, cnt, shadow) with no combinational path from any input, out_rdy included.
REQ-032 The counter SHALL never exceed POS-1; there is no wrap-around within a readout.

Reset
REQ-033 When rst_n=0, the block SHALL asynchronously force the state to IDLE and set cnt, the shadow register, out_vld, out_last, busy and done to 0; this applies mid-readout as well.
REQ-034 After rst_n deasserts, the first start SHALL be accepted on the next rising edge.

Verification
REQ-035 Set pool_lin byte k = k (k=0..26), pulse start with out_rdy=1 -> beats cnt0 (d1=0, d2=9, d3=18) through cnt8 (d1=8, d2=17, d3=26); out_last high only on cnt8; done pulses one cycle later.
REQ-036 Same data with out_rdy low for 3 cycles at cnt4 -> out_cnt=4, d1=4, d2=13, d3=22 held for 3 cycles; the sequence resumes with no loss or duplication.
REQ-037 Change pool_lin to all 0xFF one cycle after start -> the streamed values still equal 0..26.
REQ-038 Pulse start again at cnt3, and also during the DONE cycle -> both ignored; exactly 9 beats and one done pulse.
REQ-039 Assert clr at cnt5 -> out_vld=0 and busy=0 next cycle, no done; a fresh start restarts at cnt0.
REQ-040 Assert rst_n=0 asynchronously at cnt2 -> all outputs 0 immediately; after release, start streams correctly from cnt0.
